// File: rtl/bsa_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package bsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } bsa_state_t;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int bsa_cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder shared by the serial controller.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Adds two WIDTH-bit operands LSB first through one fa_cell, one bit per clock.
// Result registers update only on the final bit and hold until the next completion.
module bit_serial_add_ctrl
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = bsa_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    bsa_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s, fa_c;

    fa_cell u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (c_q),
        .sum   (fa_s),
        .carry (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    s_sh_d  = '0;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
                c_d    = fa_c;
                if (cnt_q == LAST) begin
                    // c_q here is the carry into the MSB, fa_c the carry out of it.
                    sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = c_q ^ fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Scoreboard bench for bit_serial_add_ctrl at WIDTH=8 (directed) and WIDTH=4 (exhaustive).
module tb_bit_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] sb8[$];
    logic [31:0] sb4[$];
    logic [31:0] exp8, exp4;
    logic [7:0]  last8;

    bit_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    bit_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Packed {cout, ovf, sum} for a w-bit add.
    function automatic logic [31:0] ref_res(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic c);
        logic [32:0] s;
        logic [31:0] mask;
        logic        am, bm, sm, ov;
        mask = (32'h1 << w) - 32'h1;
        s    = {1'b0, a & mask} + {1'b0, b & mask} + 33'(c);
        am   = a[w-1];
        bm   = b[w-1];
        sm   = s[w-1];
        ov   = (am == bm) && (sm != am);
        return (32'(s[w]) << (w + 1)) | (32'(ov) << w) | (s[31:0] & mask);
    endfunction

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (sb8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
            else begin
                exp8 = sb8.pop_front();
                chk("res8", {22'b0, cout8, ovf8, sum8}, exp8);
            end
        end
        if (rst_n && done4) begin
            if (sb4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
            else begin
                exp4 = sb4.pop_front();
                chk("res4", {26'b0, cout4, ovf4, sum4}, exp4);
            end
        end
    end

    task automatic wait_done(input bit w4, output time t);
        bit seen;
        seen = 1'b0;
        t    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((w4 ? done4 : done8) === 1'b1) begin
                seen = 1'b1;
                t    = $time;
            end
        end
        if (!seen) chk(w4 ? "timeout4" : "timeout8", 32'd0, 32'd1);
    endtask

    task automatic op8_timed(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [31:0] r;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = ~a; b8 = b ^ 8'h5A; cin8 = ~c;
        r = ref_res(8, 32'(a), 32'(b), c);
        sb8.push_back(r);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy8), 32'd1);
            chk("done_run", 32'(done8), 32'd0);
            if (k == 4) chk("sum_hold", 32'(sum8), 32'(last8));
        end
        @(negedge clk);
        chk("done_final", 32'(done8), 32'd1);
        chk("busy_final", 32'(busy8), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done8), 32'd0);
        chk("sum_idle", 32'(sum8), r & 32'hFF);
        last8 = r[7:0];
    endtask

    initial begin
        time t1, t2;
        int  stale;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        last8 = '0;
        #12;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_res8", {22'b0, cout8, ovf8, sum8}, 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_res4", {26'b0, cout4, ovf4, sum4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8_timed(8'h5A, 8'h3C, 1'b0);
        op8_timed(8'hFF, 8'h01, 1'b0);
        op8_timed(8'hFF, 8'h00, 1'b1);
        op8_timed(8'h7F, 8'h00, 1'b1);
        op8_timed(8'h80, 8'h80, 1'b0);

        // start during RUN must be ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h00;
        sb8.push_back(ref_res(8, 32'h10, 32'h01, 1'b0));
        repeat (3) @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done(1'b0, t1);
        chk("ign_sum", 32'(sum8), 32'h11);
        repeat (12) @(negedge clk);
        chk("ign_queue", 32'(sb8.size()), 32'd0);

        // start held through DONE: back-to-back accept
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h21; b8 = 8'h12; cin8 = 1'b1;
        @(posedge clk);
        #1;
        sb8.push_back(ref_res(8, 32'h21, 32'h12, 1'b1));
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
        sb8.push_back(ref_res(8, 32'h33, 32'h44, 1'b0));
        wait_done(1'b0, t1);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done(1'b0, t2);
        chk("b2b_gap", 32'(t2 - t1), 32'd90);
        @(negedge clk);
        chk("b2b_queue", 32'(sb8.size()), 32'd0);

        // async reset mid-RUN
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        sb8.push_back(ref_res(8, 32'hC3, 32'h3C, 1'b1));
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb8.delete();
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_res", {22'b0, cout8, ovf8, sum8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) stale++;
        end
        chk("stale_done", 32'(stale), 32'd0);
        last8 = '0;
        op8_timed(8'h01, 8'h02, 1'b0);

        // WIDTH=4 exhaustive
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic);
                    @(posedge clk);
                    #1;
                    start4 = 1'b0;
                    sb4.push_back(ref_res(4, 32'(ia), 32'(ib), 1'(ic)));
                    wait_done(1'b1, t1);
                end
            end
        end
        @(negedge clk);
        chk("q8_empty", 32'(sb8.size()), 32'd0);
        chk("q4_empty", 32'(sb4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
